alu_op_sequencer: RTL

//  Hardware control sequencer that drives data_path's bus/register enables for one

---
 rtl/cpu_ctrl_pkg.sv | 31 +++
 rtl/reg_sel_decoder.sv | 18 +
 rtl/alu_op_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package cpu_ctrl_pkg;

  localparam int NREG_DEFAULT = 16;
  localparam int OPW_DEFAULT  = 5;

  // One micro-step per state; IDLE and DONE are the only states that accept start.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    T_Y      = 3'd1,
    T_OP     = 3'd2,
    T_ZLO    = 3'd3,
    T_ZHI    = 3'd4,
    T_MDR    = 3'd5,
    T_MDROUT = 3'd6,
    DONE     = 3'd7
  } state_t;

  localparam logic [4:0] OP_AND = 5'b00001;
  localparam logic [4:0] OP_OR  = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_MUL = 5'b01000;
  localparam logic [4:0] OP_DIV = 5'b01001;

  // MUL/DIV produce a 64-bit result that goes to HI/LO instead of the register file.
  function automatic logic is_two_word(input logic [4:0] opc);
    return (opc == OP_MUL) || (opc == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// 4-bit register index plus enable to one-hot register select.
module reg_sel_decoder #(
  parameter int N = 16
) (
  input  logic [3:0]   i_idx,
  input  logic         i_en,
  output logic [N-1:0] o_sel
);

  // One-hot decode; all zero when not enabled.
  always_comb begin
    o_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      o_sel[i] = i_en && (i_idx == i[3:0]);
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Moore control sequencer driving data_path enables for one instruction:
// reg-reg ALU op, two-word MUL/DIV into HI/LO, or load-immediate via MDR.
module alu_op_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int OPW  = OPW_DEFAULT
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic            start,
  input  logic            is_imm,
  input  logic [OPW-1:0]  opcode,
  input  logic [3:0]      ra,
  input  logic [3:0]      rb,
  input  logic [3:0]      rc,
  output logic            busy,
  output logic            done,
  output logic [NREG-1:0] Rout,
  output logic [NREG-1:0] Rin,
  output logic            Yin,
  output logic            Zlowin,
  output logic            ZHighin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            MDRin,
  output logic            MDRout,
  output logic            Read,
  output logic            HIin,
  output logic            LOin,
  output logic [OPW-1:0]  op
);

  state_t         r_state;
  state_t         w_next;
  logic [OPW-1:0] r_opcode;
  logic [3:0]     r_ra;
  logic [3:0]     r_rb;
  logic [3:0]     r_rc;

  logic           w_accept;
  logic           w_two_word;
  logic           w_rout_en;
  logic [3:0]     w_rout_idx;
  logic           w_rin_en;

  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_two_word = is_two_word(r_opcode);

  // State register.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Instruction fields captured only on accept; the imm/reg-reg choice lives in the
  // state path itself, so is_imm needs no holding register.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_opcode <= '0;
      r_ra     <= '0;
      r_rb     <= '0;
      r_rc     <= '0;
    end else if (w_accept) begin
      r_opcode <= opcode;
      r_ra     <= ra;
      r_rb     <= rb;
      r_rc     <= rc;
    end
  end

  // Next-state and output decode from registered state and latched fields.
  always_comb begin
    w_next     = r_state;
    busy       = 1'b0;
    done       = 1'b0;
    Yin        = 1'b0;
    Zlowin     = 1'b0;
    ZHighin    = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    Read       = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    op         = '0;
    w_rout_en  = 1'b0;
    w_rout_idx = r_rb;
    w_rin_en   = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = is_imm ? T_MDR : T_Y;
        end
      end
      T_Y: begin
        busy       = 1'b1;
        w_rout_en  = 1'b1;
        w_rout_idx = r_rb;
        Yin        = 1'b1;
        w_next     = T_OP;
      end
      T_OP: begin
        busy       = 1'b1;
        w_rout_en  = 1'b1;
        w_rout_idx = r_rc;
        op         = r_opcode;
        Zlowin     = 1'b1;
        ZHighin    = 1'b1;
        w_next     = T_ZLO;
      end
      T_ZLO: begin
        busy    = 1'b1;
        Zlowout = 1'b1;
        if (w_two_word) begin
          LOin   = 1'b1;
          w_next = T_ZHI;
        end else begin
          w_rin_en = 1'b1;
          w_next   = DONE;
        end
      end
      T_ZHI: begin
        busy     = 1'b1;
        Zhighout = 1'b1;
        HIin     = 1'b1;
        w_next   = DONE;
      end
      T_MDR: begin
        busy   = 1'b1;
        Read   = 1'b1;
        MDRin  = 1'b1;
        w_next = T_MDROUT;
      end
      T_MDROUT: begin
        busy     = 1'b1;
        MDRout   = 1'b1;
        w_rin_en = 1'b1;
        w_next   = DONE;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        if (start) begin
          w_next = is_imm ? T_MDR : T_Y;
        end else begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  reg_sel_decoder #(.N(NREG)) u_rout_dec (
    .i_idx (w_rout_idx),
    .i_en  (w_rout_en),
    .o_sel (Rout)
  );

  reg_sel_decoder #(.N(NREG)) u_rin_dec (
    .i_idx (r_ra),
    .i_en  (w_rin_en),
    .o_sel (Rin)
  );

endmodule
